// File: rtl/crp16_fetch_unit.sv
// rtl/crp16_fetch_unit.sv - CRP16 instruction fetch unit with in-order instruction queue
//
// Fetches sequential instruction words from an asynchronous-read memory into
// a DEPTH-entry queue and presents the head entry to decode.
// Optional feature macro: CRP16_FETCH_BYPASS_EN (empty-queue combinational bypass).
//
// Ports:
//   clock, reset          - rising-edge clock, asynchronous active-high reset
//   mem_addr, mem_rden    - fetch address (current fetch pc) and fetch strobe
//   mem_q, mem_ready      - same-cycle read data, memory port available
//   instr, instr_pc       - head instruction and its address (zero when not valid)
//   instr_valid           - head entry present
//   instr_ready           - decode accepts the head entry
//   redirect, redirect_addr - flush queue and restart fetch at redirect_addr
//   halt                  - stop fetching; queued entries still drain
//   count                 - occupied queue entries
module crp16_fetch_unit #(
    parameter int unsigned          ADDR_W   = 16,
    parameter int unsigned          DATA_W   = 16,
    parameter int unsigned          DEPTH    = 4,
    parameter logic [ADDR_W-1:0]    RESET_PC = '0
) (
    input  logic                     clock,
    input  logic                     reset,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic                     mem_rden,
    input  logic [DATA_W-1:0]        mem_q,
    input  logic                     mem_ready,
    output logic [DATA_W-1:0]        instr,
    output logic [ADDR_W-1:0]        instr_pc,
    output logic                     instr_valid,
    input  logic                     instr_ready,
    input  logic                     redirect,
    input  logic [ADDR_W-1:0]        redirect_addr,
    input  logic                     halt,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;

    // Queue storage is deliberately unreset; count gates every read of it.
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [ADDR_W-1:0] pc_q   [DEPTH];

    logic queue_empty;
    logic push;
    logic pop;
    logic q_pop;

    assign queue_empty = (count_q == '0);
    assign mem_addr    = fetch_pc_q;
    // Full blocks the fetch even if a pop happens this cycle.
    assign mem_rden    = mem_ready & ~redirect & ~halt & (count_q < CNT_W'(DEPTH));
    assign count       = count_q;

`ifdef CRP16_FETCH_BYPASS_EN
    logic bypass_hit;
    assign bypass_hit  = queue_empty & mem_rden;
    assign instr_valid = ~queue_empty | bypass_hit;
    assign instr       = ~queue_empty ? data_q[head_q] : (bypass_hit ? mem_q : '0);
    assign instr_pc    = ~queue_empty ? pc_q[head_q] : (bypass_hit ? fetch_pc_q : '0);
    // A word consumed straight off the bus never enters the queue.
    assign push        = mem_rden & ~(bypass_hit & instr_ready);
`else
    assign instr_valid = ~queue_empty;
    assign instr       = instr_valid ? data_q[head_q] : '0;
    assign instr_pc    = instr_valid ? pc_q[head_q] : '0;
    assign push        = mem_rden;
`endif

    assign pop   = instr_valid & instr_ready & ~redirect;
    // Only pops of real queue entries move the head (a bypass pop does not).
    assign q_pop = pop & ~queue_empty;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        if (redirect) begin
            fetch_pc_d = redirect_addr;
            head_d     = '0;
            tail_d     = '0;
            count_d    = '0;
        end else begin
            if (push) begin
                tail_d     = tail_q + PTR_W'(1);
                fetch_pc_d = fetch_pc_q + ADDR_W'(1);
            end
            if (q_pop) begin
                head_d = head_q + PTR_W'(1);
            end
            case ({push, q_pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fetch_pc_q <= RESET_PC;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            data_q[tail_q] <= mem_q;
            pc_q[tail_q]   <= fetch_pc_q;
        end
    end

endmodule

// File: tb/tb_crp16_fetch_unit.sv
// tb/tb_crp16_fetch_unit.sv - self-checking bench for crp16_fetch_unit
module tb_crp16_fetch_unit;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] mem_addr, mem_addr2;
    logic        mem_rden, mem_rden2;
    logic [15:0] mem_q, mem_q2;
    logic        mem_ready = 1'b0;
    logic [15:0] instr, instr2;
    logic [15:0] instr_pc, instr_pc2;
    logic        instr_valid, instr_valid2;
    logic        instr_ready = 1'b0;
    logic        redirect = 1'b0;
    logic [15:0] redirect_addr = 16'h0;
    logic        halt = 1'b0;
    logic [2:0]  count, count2;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    function automatic logic [15:0] memf(input logic [15:0] a);
        return a ^ 16'hA5C3;
    endfunction

    assign mem_q  = memf(mem_addr);
    assign mem_q2 = memf(mem_addr2);

    crp16_fetch_unit #(.ADDR_W(16), .DATA_W(16), .DEPTH(4), .RESET_PC(16'h0000)) dut (
        .clock(clock), .reset(reset), .mem_addr(mem_addr), .mem_rden(mem_rden),
        .mem_q(mem_q), .mem_ready(mem_ready), .instr(instr), .instr_pc(instr_pc),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .redirect(redirect),
        .redirect_addr(redirect_addr), .halt(halt), .count(count)
    );

    crp16_fetch_unit #(.ADDR_W(16), .DATA_W(16), .DEPTH(4), .RESET_PC(16'hFFFE)) dut2 (
        .clock(clock), .reset(reset), .mem_addr(mem_addr2), .mem_rden(mem_rden2),
        .mem_q(mem_q2), .mem_ready(mem_ready), .instr(instr2), .instr_pc(instr_pc2),
        .instr_valid(instr_valid2), .instr_ready(instr_ready), .redirect(redirect),
        .redirect_addr(redirect_addr), .halt(halt), .count(count2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a FIFO of {data, pc} words and a fetch pointer.
    logic [31:0] mq[$];
    logic [15:0] mpc = 16'h0000;

    function automatic logic model_rden();
        return mem_ready && !redirect && !halt && (mq.size() < 4);
    endfunction

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            mq.delete();
            mpc = 16'h0000;
        end else begin
            logic do_pop, do_push;
            do_pop  = (mq.size() != 0) && instr_ready && !redirect;
            do_push = model_rden();
            if (redirect) begin
                mq.delete();
                mpc = redirect_addr;
            end else begin
                if (do_pop) void'(mq.pop_front());
                if (do_push) begin
                    mq.push_back({memf(mpc), mpc});
                    mpc = mpc + 16'h1;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clock);
            #3;
            chk("count", 32'(count), 32'(mq.size()));
            chk("instr_valid", 32'(instr_valid), 32'(mq.size() != 0));
            chk("instr", 32'(instr), (mq.size() != 0) ? 32'(mq[0][31:16]) : 32'h0);
            chk("instr_pc", 32'(instr_pc), (mq.size() != 0) ? 32'(mq[0][15:0]) : 32'h0);
            chk("mem_addr", 32'(mem_addr), 32'(mpc));
            chk("mem_rden", 32'(mem_rden), 32'(model_rden()));
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic do_reset();
        reset = 1'b1; mem_ready = 1'b0; instr_ready = 1'b0;
        redirect = 1'b0; halt = 1'b0;
        cyc(1);
        reset = 1'b0;
    endtask

    initial begin
        logic [19:0] ir_pat;
        logic [19:0] mr_pat;
        ir_pat = 20'b1011_0010_0110_1100_0101;
        mr_pat = 20'b1111_1011_1101_1111_1011;

        // Reset state
        cyc(1);
        #1;
        chk("rst_valid", 32'(instr_valid), 32'h0);
        chk("rst_instr", 32'(instr), 32'h0);
        chk("rst_pc", 32'(instr_pc), 32'h0);
        chk("rst_count", 32'(count), 32'h0);
        chk("rst_addr", 32'(mem_addr), 32'h0);
        chk("rst_addr2", 32'(mem_addr2), 32'hFFFE);
        cyc(1);

        // Streaming, including address wrap on the second instance
        reset = 1'b0; mem_ready = 1'b1; instr_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #2;
            if (i == 0) begin
                chk("str_valid0", 32'(instr_valid), 32'h0);
            end else begin
                chk("str_pc", 32'(instr_pc), 32'(i - 1));
                chk("str_count", 32'(count), 32'h1);
                chk("str_instr", 32'(instr), 32'(16'(i - 1) ^ 16'hA5C3));
            end
            if (i == 1) chk("wrap_pc_fffe", 32'(instr_pc2), 32'hFFFE);
            if (i == 2) chk("wrap_pc_ffff", 32'(instr_pc2), 32'hFFFF);
            if (i == 3) chk("wrap_pc_0000", 32'(instr_pc2), 32'h0000);
            cyc(1);
        end

        // Full stall
        do_reset();
        mem_ready = 1'b1;
        cyc(6);
        #2;
        chk("full_count", 32'(count), 32'h4);
        chk("full_rden", 32'(mem_rden), 32'h0);
        chk("full_addr", 32'(mem_addr), 32'h4);
        instr_ready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            chk("drain_pc", 32'(instr_pc), 32'(j));
            cyc(1);
            #2;
        end

        // Redirect with three entries queued
        do_reset();
        mem_ready = 1'b1;
        cyc(3);
        #2;
        chk("redir_pre_count", 32'(count), 32'h3);
        redirect = 1'b1; redirect_addr = 16'h0040; instr_ready = 1'b1;
        cyc(1);
        redirect = 1'b0;
        #2;
        chk("redir_count", 32'(count), 32'h0);
        chk("redir_addr", 32'(mem_addr), 32'h0040);
        cyc(1);
        #2;
        chk("redir_first_pc", 32'(instr_pc), 32'h0040);
        chk("redir_first_valid", 32'(instr_valid), 32'h1);

        // Halt drains two entries then holds fetch pc
        do_reset();
        mem_ready = 1'b1;
        cyc(2);
        halt = 1'b1; instr_ready = 1'b1;
        #2;
        chk("halt_count", 32'(count), 32'h2);
        chk("halt_pc0", 32'(instr_pc), 32'h0);
        cyc(1);
        #2;
        chk("halt_pc1", 32'(instr_pc), 32'h1);
        cyc(1);
        #2;
        chk("halt_empty", 32'(instr_valid), 32'h0);
        chk("halt_addr", 32'(mem_addr), 32'h2);
        halt = 1'b0; mem_ready = 1'b0;
        cyc(3);
        #2;
        chk("mr0_count", 32'(count), 32'h0);
        chk("mr0_addr", 32'(mem_addr), 32'h2);

        // Pointer wrap: interleaved pushes and pops, then redirect near the top
        do_reset();
        for (int k = 0; k < 20; k++) begin
            mem_ready   = mr_pat[k];
            instr_ready = ir_pat[k];
            cyc(1);
        end
        redirect = 1'b1; redirect_addr = 16'hFFFE;
        cyc(1);
        redirect = 1'b0; mem_ready = 1'b1; instr_ready = 1'b1;
        cyc(4);

        // Asynchronous reset mid-cycle with three entries queued
        do_reset();
        mem_ready = 1'b1;
        cyc(3);
        #1;
        reset = 1'b1;
        #1;
        chk("arst_valid", 32'(instr_valid), 32'h0);
        chk("arst_addr", 32'(mem_addr), 32'h0);
        chk("arst_count", 32'(count), 32'h0);
        cyc(1);
        reset = 1'b0;
        cyc(1);
        #2;
        chk("arst_first_pc", 32'(instr_pc), 32'h0);
        cyc(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
